// File: rtl/rca_8_pkg.sv
// Shared arithmetic constants for the ripple-carry adder slice.
package rca_8_pkg;

  // Operand width of the adder; only 8 is supported.
  localparam int unsigned RCA_WIDTH = 8;

endpackage

// File: rtl/rca_8_full_adder.sv
// full_adder: one-bit full adder cell, purely combinational.
// Ports:
//   a, b  - operand bits
//   ci    - carry in
//   s     - sum bit
//   co    - carry out (majority of a, b, ci)
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/rca_8.sv
// rca_8: 8-bit ripple-carry adder with a registered copy of the result.
// Ports:
//   clk    - system clock, rising edge active
//   rst    - synchronous active-high reset, clears sum_q/cout_q only
//   A, B   - unsigned operands
//   cin    - carry into bit 0
//   sum    - combinational (A + B + cin) mod 2^WIDTH
//   cout   - combinational carry out of the MSB
//   sum_q  - sum registered on clk
//   cout_q - cout registered on clk
module rca_8
  import rca_8_pkg::*;
#(
  parameter int unsigned WIDTH = RCA_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic [WIDTH-1:0] sum_q,
  output logic             cout_q
);

  // Carry chain: c[0] is the carry in, c[WIDTH] the carry out.
  logic [WIDTH:0] c;

  assign c[0] = cin;

  // Strict LSB-to-MSB ripple through one full adder per bit.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    full_adder u_fa (
      .a  (A[i]),
      .b  (B[i]),
      .ci (c[i]),
      .s  (sum[i]),
      .co (c[i+1])
    );
  end

  assign cout = c[WIDTH];

  // Output registers; reset clears only the registered copy.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      sum_q  <= sum;
      cout_q <= cout;
    end
  end

endmodule

// File: tb/tb_rca_8.sv
// Self-checking bench for rca_8: directed vectors, reset behaviour and a
// random sweep against a 9-bit reference, with a scoreboard for the
// registered outputs.
module tb_rca_8;

  logic       clk;
  logic       rst;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic [7:0] sum;
  logic       cout;
  logic [7:0] sum_q;
  logic       cout_q;

  int unsigned checks;
  int unsigned passed;
  logic [8:0]  sb_q[$];

  rca_8 dut (
    .clk    (clk),
    .rst    (rst),
    .A      (a),
    .B      (b),
    .cin    (cin),
    .sum    (sum),
    .cout   (cout),
    .sum_q  (sum_q),
    .cout_q (cout_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d (0x%h) expected %0d (0x%h)", tag, obs, obs, exp, exp);
  endtask

  // Drive one vector at the falling edge, check the combinational result,
  // then check the registered result one rising edge later via the scoreboard.
  task automatic step(input string tag, input logic [7:0] av, input logic [7:0] bv,
                      input logic civ, input logic rv, input logic [8:0] exp_comb);
    logic [8:0] exp_reg;
    @(negedge clk);
    a   = av;
    b   = bv;
    cin = civ;
    rst = rv;
    sb_q.push_back(rv ? 9'd0 : exp_comb);
    #1;
    check({tag, "_comb"}, {cout, sum}, exp_comb);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      checks++;
      $error("FAIL %s_reg: scoreboard empty, observed %0d expected an entry", tag, {cout_q, sum_q});
    end else begin
      exp_reg = sb_q.pop_front();
      check({tag, "_reg"}, {cout_q, sum_q}, exp_reg);
    end
  endtask

  initial begin
    logic [8:0]  wide_b;
    logic [7:0]  ra;
    logic [7:0]  rb;
    logic        rc;
    logic [8:0]  ref9;
    checks = 0;
    passed = 0;
    a   = 8'd0;
    b   = 8'd0;
    cin = 1'b0;
    rst = 1'b1;

    // Reset held for two cycles: registered outputs clear, comb stays live.
    step("rst0", 8'd0, 8'd0, 1'b0, 1'b1, 9'd0);
    step("rst1", 8'd10, 8'd20, 1'b1, 1'b1, 9'd31);

    // Release and apply the first vector; one edge later the register follows.
    step("v120_240", 8'd120, 8'd240, 1'b0, 1'b0, {1'b1, 8'd104});

    // Reset mid-operation: register clears while comb result remains 104.
    step("rst_mid", 8'd120, 8'd240, 1'b0, 1'b1, {1'b1, 8'd104});

    // Operand wider than 8 bits is truncated to its low byte (256 -> 0).
    wide_b = 9'd256;
    step("v169_256", 8'd169, wide_b[7:0], 1'b1, 1'b0, {1'b0, 8'd170});
    step("v53_250", 8'd53, 8'd250, 1'b0, 1'b0, {1'b1, 8'd47});
    step("v1_50", 8'd1, 8'd50, 1'b1, 1'b0, {1'b0, 8'd52});
    step("v50_100", 8'd50, 8'd100, 1'b0, 1'b0, {1'b0, 8'd150});

    // Full carry ripple through all eight stages.
    step("ripple_ff_00", 8'hff, 8'h00, 1'b1, 1'b0, {1'b1, 8'd0});
    step("max_ff_ff", 8'hff, 8'hff, 1'b1, 1'b0, {1'b1, 8'd255});
    step("zero", 8'h00, 8'h00, 1'b0, 1'b0, 9'd0);

    // Random sweep against the 9-bit reference A + B + cin.
    for (int i = 0; i < 300; i++) begin
      ra   = 8'($urandom_range(0, 255));
      rb   = 8'($urandom_range(0, 255));
      rc   = 1'($urandom_range(0, 1));
      ref9 = 9'(ra) + 9'(rb) + 9'(rc);
      step("rand", ra, rb, rc, 1'b0, ref9);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
